// File: rtl/bsg_mcl_host_req_arb.sv
// Credit-gated two-port round-robin arbiter feeding the manycore-link request path
// through a one-entry output register, with host request credit tracking.
module bsg_mcl_host_req_arb #(
    parameter int mc_fifo_width_p = 128,
    parameter int max_credits_p   = 16,
    parameter int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       req0_v_i,
    input  logic [mc_fifo_width_p-1:0] req0_data_i,
    output logic                       req0_ready_o,

    input  logic                       req1_v_i,
    input  logic [mc_fifo_width_p-1:0] req1_data_i,
    output logic                       req1_ready_o,

    output logic                       link_v_o,
    output logic [mc_fifo_width_p-1:0] link_data_o,
    input  logic                       link_ready_i,

    input  logic                       credit_return_v_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic [credit_width_lp-1:0] outstanding_o,
    output logic                       credit_err_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);

    logic [credit_width_lp-1:0] credits_r;
    logic                       last_r;
    logic                       valid_r;
    logic [mc_fifo_width_p-1:0] data_r;
    logic                       credit_err_r;

    logic slot_free;
    logic can_grant;
    logic grant0;
    logic grant1;
    logic accept;
    logic at_max;
    logic credit_inc;

    // The slot frees up in the same cycle the link drains it, which keeps throughput at one per cycle.
    assign slot_free = !valid_r || link_ready_i;
    assign can_grant = slot_free && (credits_r != '0);

    assign grant0 = can_grant && req0_v_i && (!req1_v_i || last_r);
    assign grant1 = can_grant && req1_v_i && (!req0_v_i || !last_r);
    assign accept = grant0 || grant1;

    // A return at max is only legal when an accept consumes a credit in the same cycle.
    assign at_max     = (credits_r == max_credits_lp);
    assign credit_inc = credit_return_v_i && (!at_max || accept);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_r    <= max_credits_lp;
            last_r       <= 1'b1;
            valid_r      <= 1'b0;
            data_r       <= '0;
            credit_err_r <= 1'b0;
        end else begin
            if (grant0) begin
                data_r  <= req0_data_i;
                valid_r <= 1'b1;
                last_r  <= 1'b0;
            end else if (grant1) begin
                data_r  <= req1_data_i;
                valid_r <= 1'b1;
                last_r  <= 1'b1;
            end else if (valid_r && link_ready_i) begin
                valid_r <= 1'b0;
            end

            if (accept && !credit_inc) begin
                credits_r <= credits_r - 1'b1;
            end else if (credit_inc && !accept) begin
                credits_r <= credits_r + 1'b1;
            end

            if (credit_return_v_i && at_max && !accept) begin
                credit_err_r <= 1'b1;
            end
        end
    end

    assign req0_ready_o  = grant0;
    assign req1_ready_o  = grant1;
    assign link_v_o      = valid_r;
    assign link_data_o   = data_r;
    assign credits_o     = credits_r;
    assign outstanding_o = max_credits_lp - credits_r;
    assign credit_err_o  = credit_err_r;

endmodule
